// File: rtl/dendy_dma_pkg.sv
// Shared types and default widths for the Dendy CPU-side DMA engine.
package dendy_dma_pkg;

  localparam int CHANNELS_DEF = 2;
  localparam int ADDR_W_DEF   = 16;
  localparam int LEN_W_DEF    = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ALIGN,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/dma_arbiter.sv
// Pending mask, start gating and lowest-index channel select with frozen grant.
module dma_arbiter
  import dendy_dma_pkg::*;
#(
  parameter  int CHANNELS = CHANNELS_DEF,
  localparam int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ce,
  input  logic [CHANNELS-1:0] start_i,
  input  logic                clr_i,
  input  logic                load_i,
  output logic [CHANNELS-1:0] busy_o,
  output logic                any_o,
  output logic [IDX_W-1:0]    nxt_o,
  output logic [CHANNELS-1:0] gnt_oh_o
);

  logic [CHANNELS-1:0] pend_q, pend_d, mask;
  logic [IDX_W-1:0]    gnt_q;

  always_comb begin
    gnt_oh_o = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (gnt_q == IDX_W'(i)) gnt_oh_o[i] = 1'b1;
  end

  // In DONE the finishing channel is masked so chaining sees only the rest.
  always_comb begin
    mask  = pend_q & ~(clr_i ? gnt_oh_o : '0);
    any_o = |mask;
    nxt_o = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (mask[i]) nxt_o = IDX_W'(i);
  end

  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d = pend_d & ~gnt_oh_o;
    pend_d = pend_d | (start_i & ~pend_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q <= '0;
      gnt_q  <= '0;
    end else if (ce) begin
      pend_q <= pend_d;
      if (load_i) gnt_q <= nxt_o;
    end
  end

  assign busy_o = pend_q;

endmodule

// File: rtl/dma_ctrl.sv
// Multi-channel bus-master DMA: halts the CPU at opcode fetch and block-copies.
// Optional DMA_ODD_ALIGN_EN adds an ALIGN cycle so the first READ is on parity 0.
module dma_ctrl
  import dendy_dma_pkg::*;
#(
  parameter  int CHANNELS = CHANNELS_DEF,
  parameter  int ADDR_W   = ADDR_W_DEF,
  parameter  int LEN_W    = LEN_W_DEF,
  localparam int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ce,
  input  logic                       m0,
  input  logic [CHANNELS-1:0]        start,
  input  logic [CHANNELS*ADDR_W-1:0] src,
  input  logic [CHANNELS*ADDR_W-1:0] dst,
  input  logic [CHANNELS*LEN_W-1:0]  len,
  input  logic [CHANNELS-1:0]        dst_inc,
  input  logic [7:0]                 I,
  output logic [ADDR_W-1:0]          A,
  output logic [7:0]                 D,
  output logic                       R,
  output logic                       W,
  output logic                       halt,
  output logic [CHANNELS-1:0]        busy,
  output logic [CHANNELS-1:0]        done
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_cfg_q [CHANNELS];
  logic [ADDR_W-1:0]   dst_cfg_q [CHANNELS];
  logic [LEN_W-1:0]    len_cfg_q [CHANNELS];
  logic [CHANNELS-1:0] inc_cfg_q;
  logic [ADDR_W-1:0]   sp_q, dp_q;
  logic [LEN_W-1:0]    cnt_q;
  logic                inc_q;
  logic [7:0]          d_q;
  logic                load, clr, any, align_ok;
  logic [IDX_W-1:0]    nxt;
  logic [CHANNELS-1:0] gnt_oh;

  dma_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .clock    (clock),
    .reset    (reset),
    .ce       (ce),
    .start_i  (start),
    .clr_i    (clr),
    .load_i   (load),
    .busy_o   (busy),
    .any_o    (any),
    .nxt_o    (nxt),
    .gnt_oh_o (gnt_oh)
  );

`ifdef DMA_ODD_ALIGN_EN
  logic par_q;

  always_ff @(posedge clock) begin
    if (reset)   par_q <= 1'b0;
    else if (ce) par_q <= ~par_q;
  end

  // Leave ALIGN only from an odd cycle so READ falls on parity 0.
  assign align_ok = par_q;
`else
  assign align_ok = 1'b1;
`endif

  assign clr = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE:  if (any) state_d = S_WAIT;
      S_WAIT: begin
        if (m0) begin
          state_d = S_ALIGN;
          load    = 1'b1;
        end
      end
      S_ALIGN: begin
        if (align_ok)
          state_d = (cnt_q == '0) ? S_DONE : S_READ;
      end
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_READ;
      S_DONE: begin
        if (any) begin
          state_d = S_ALIGN;
          load    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    A    = '0;
    R    = 1'b0;
    W    = 1'b0;
    halt = 1'b0;
    done = '0;
    unique case (state_q)
      S_ALIGN: halt = 1'b1;
      S_READ: begin
        halt = 1'b1;
        A    = sp_q;
        R    = 1'b1;
      end
      S_WRITE: begin
        halt = 1'b1;
        A    = dp_q;
        W    = 1'b1;
      end
      S_DONE: begin
        halt = 1'b1;
        done = gnt_oh;
      end
      default: ;
    endcase
  end

  assign D = d_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        src_cfg_q[i] <= '0;
        dst_cfg_q[i] <= '0;
        len_cfg_q[i] <= '0;
      end
      inc_cfg_q <= '0;
    end else if (ce) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (start[i] && !busy[i]) begin
          src_cfg_q[i] <= src[i*ADDR_W +: ADDR_W];
          dst_cfg_q[i] <= dst[i*ADDR_W +: ADDR_W];
          len_cfg_q[i] <= len[i*LEN_W +: LEN_W];
          inc_cfg_q[i] <= dst_inc[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      dp_q    <= '0;
      cnt_q   <= '0;
      inc_q   <= 1'b0;
      d_q     <= '0;
    end else if (ce) begin
      state_q <= state_d;
      if (load) begin
        sp_q  <= src_cfg_q[nxt];
        dp_q  <= dst_cfg_q[nxt];
        cnt_q <= len_cfg_q[nxt];
        inc_q <= inc_cfg_q[nxt];
      end else if (state_q == S_WRITE) begin
        sp_q  <= sp_q + ADDR_W'(1);
        if (inc_q) dp_q <= dp_q + ADDR_W'(1);
        cnt_q <= cnt_q - LEN_W'(1);
      end
      if (state_q == S_READ) d_q <= I;
    end
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Self-checking bench for dma_ctrl: vector table plus bus-op scoreboard.
module tb_dma_ctrl;

  localparam int CH = 2;
  localparam int AW = 16;
  localparam int LW = 9;
`ifdef DMA_ODD_ALIGN_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ce = 1'b1;
  logic          m0 = 1'b1;
  logic [CH-1:0] start = '0;
  logic [CH-1:0] dst_inc = '0;
  logic [CH*AW-1:0] src = '0;
  logic [CH*AW-1:0] dst = '0;
  logic [CH*LW-1:0] len = '0;
  logic [7:0]    I;
  logic [AW-1:0] A;
  logic [7:0]    D;
  logic          R, W, halt;
  logic [CH-1:0] busy, done;

  always #20 clock = ~clock;

  dma_ctrl #(.CHANNELS(CH), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clock(clock), .reset(reset), .ce(ce), .m0(m0),
    .start(start), .src(src), .dst(dst), .len(len),
    .dst_inc(dst_inc), .I(I), .A(A), .D(D), .R(R), .W(W),
    .halt(halt), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
  } op_t;

  typedef struct {
    int          ch;
    logic [15:0] s;
    logic [15:0] d;
    int          n;
    bit          inc;
    int          par;
    int          dly;
    int          eh;
    string       nm;
  } vec_t;

  op_t   sb[$];
  op_t   e;
  vec_t  tbl[6];
  int    nvec = 0;
  int    nbad = 0;
  int    halt_cnt = 0;
  int    hfall = 0;
  int    wr_cnt = 0;
  int    done_cnt[CH];
  int    par = 0;
  bit    slow = 1'b0;
  int    cdiv = 0;
  bit    prev_ce = 1'b1;
  bit    prev_halt = 1'b0;
  logic [63:0] snap, prev_snap;

  function automatic logic [7:0] pat(logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign I = R ? pat(A) : 8'h00;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  always @(posedge clock) begin
    if (reset) par <= 0;
    else if (ce) par <= par ^ 1;
  end

  always @(posedge clock) begin
    #1;
    cdiv = (cdiv == 2) ? 0 : cdiv + 1;
    ce = !slow || (cdiv == 0);
  end

  always @(negedge clock) begin
    snap = 64'({A, D, R, W, halt, busy, done});
    if (!reset && !ce && !prev_ce)
      chk("hold", snap, prev_snap);
    if (!reset && ce) begin
      if (halt) halt_cnt++;
      if (prev_halt && !halt) hfall++;
      prev_halt = halt;
      for (int i = 0; i < CH; i++)
        if (done[i]) done_cnt[i]++;
      if (R && W) chk("r_and_w", 1, 0);
      if (R || W) begin
        if (W) wr_cnt++;
        if (sb.size() == 0) begin
          nvec++;
          nbad++;
          $display("FAIL extra_op: got A=%0h W=%0b expected none", A, W);
        end else begin
          e = sb.pop_front();
          chk("op_kind", 64'(W), 64'(e.wr));
          chk("op_addr", 64'(A), 64'(e.a));
          if (W) chk("op_data", 64'(D), 64'(e.d));
        end
      end
    end
    prev_snap = snap;
    prev_ce = ce;
  end

  task automatic push_ops(logic [15:0] s, logic [15:0] d, int n, bit inc);
    logic [15:0] sa, da;
    sa = s;
    da = d;
    for (int k = 0; k < n; k++) begin
      sb.push_back('{1'b0, sa, 8'h00});
      sb.push_back('{1'b1, da, pat(sa)});
      sa = sa + 16'd1;
      if (inc) da = da + 16'd1;
    end
  endtask

  task automatic set_cfg(int ch, logic [15:0] s, logic [15:0] d, int n, bit inc);
    src[ch*AW +: AW] = s;
    dst[ch*AW +: AW] = d;
    len[ch*LW +: LW] = LW'(n);
    dst_inc[ch] = inc;
  endtask

  task automatic wait_par(int want);
    int k;
    k = 0;
    tick();
    while (!(ce && par == want) && k < 20) begin
      tick();
      k++;
    end
  endtask

  task automatic clr_counts();
    halt_cnt = 0;
    hfall = 0;
    wr_cnt = 0;
    for (int i = 0; i < CH; i++) done_cnt[i] = 0;
  endtask

  task automatic wait_idle(string nm);
    int k;
    k = 0;
    while (busy != '0 && k < 4000) begin
      tick();
      k++;
    end
    if (busy != '0) chk({nm, "_timeout"}, 64'(busy), 0);
    tick();
    tick();
  endtask

  task automatic run_vec(vec_t v);
    set_cfg(v.ch, v.s, v.d, v.n, v.inc);
    push_ops(v.s, v.d, v.n, v.inc);
    if (v.dly > 0) m0 = 1'b0;
    wait_par(v.par);
    clr_counts();
    start[v.ch] = 1'b1;
    tick();
    start = '0;
    for (int k = 0; k < v.dly; k++) tick();
    if (v.dly > 0) begin
      chk({v.nm, "_nohalt"}, 64'(halt), 0);
      m0 = 1'b1;
    end
    wait_idle(v.nm);
    chk({v.nm, "_halt"}, 64'(halt_cnt), 64'(v.eh));
    chk({v.nm, "_done"}, 64'(done_cnt[v.ch]), 1);
    chk({v.nm, "_done_other"}, 64'(done_cnt[1-v.ch]), 0);
    chk({v.nm, "_sb_empty"}, 64'(sb.size()), 0);
    sb.delete();
  endtask

  initial begin
    tbl[0] = '{0, 16'h0200, 16'h2004, 256, 1'b0, 0, 0, 514, "oam_even"};
    tbl[1] = '{0, 16'h0200, 16'h2004, 256, 1'b0, 1, 0, 514 + EXTRA, "oam_odd"};
    tbl[2] = '{1, 16'hFFFE, 16'h0300, 3, 1'b1, 0, 0, 8, "ch1_wrap"};
    tbl[3] = '{0, 16'h0000, 16'h0000, 0, 1'b1, 0, 0, 2, "len0"};
    tbl[4] = '{1, 16'h1234, 16'h4000, 5, 1'b1, 1, 5, 12 + EXTRA, "m0_wait"};
    tbl[5] = '{0, 16'hFFFF, 16'h0000, 1, 1'b1, 0, 0, 4, "len1"};

    for (int k = 0; k < 3; k++) tick();
    chk("rst_A", 64'(A), 0);
    chk("rst_D", 64'(D), 0);
    chk("rst_RW", 64'({R, W}), 0);
    chk("rst_halt", 64'(halt), 0);
    chk("rst_busy_done", 64'({busy, done}), 0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) run_vec(tbl[v]);

    // Both channels at once: ch0 first, ch1 chained with halt held.
    set_cfg(0, 16'h0200, 16'h2004, 256, 1'b0);
    set_cfg(1, 16'hFFFE, 16'h0300, 3, 1'b1);
    push_ops(16'h0200, 16'h2004, 256, 1'b0);
    push_ops(16'hFFFE, 16'h0300, 3, 1'b1);
    wait_par(0);
    clr_counts();
    start = 2'b11;
    tick();
    start = '0;
    wait_idle("chain");
    chk("chain_halt", 64'(halt_cnt), 522);
    chk("chain_hfall", 64'(hfall), 1);
    chk("chain_done0", 64'(done_cnt[0]), 1);
    chk("chain_done1", 64'(done_cnt[1]), 1);
    chk("chain_sb_empty", 64'(sb.size()), 0);
    sb.delete();

    // Restart attempts while busy, held through the DONE cycle.
    set_cfg(0, 16'h0500, 16'h2004, 20, 1'b0);
    push_ops(16'h0500, 16'h2004, 20, 1'b0);
    wait_par(0);
    clr_counts();
    start[0] = 1'b1;
    tick();
    start = '0;
    for (int k = 0; k < 10; k++) tick();
    set_cfg(0, 16'h0900, 16'h0100, 5, 1'b1);
    start[0] = 1'b1;
    for (int k = 0; k < 200 && busy[0]; k++) tick();
    start = '0;
    tick();
    tick();
    chk("restart_busy", 64'(busy), 0);
    chk("restart_done", 64'(done_cnt[0]), 1);
    chk("restart_halt", 64'(halt_cnt), 42);
    chk("restart_sb_empty", 64'(sb.size()), 0);
    sb.delete();

    // ce active one cycle in three.
    slow = 1'b1;
    run_vec(tbl[2]);
    run_vec(tbl[5]);
    slow = 1'b0;
    tick();

    // Reset after the tenth byte.
    set_cfg(0, 16'h0200, 16'h2004, 256, 1'b0);
    push_ops(16'h0200, 16'h2004, 256, 1'b0);
    wait_par(0);
    clr_counts();
    start[0] = 1'b1;
    tick();
    start = '0;
    for (int k = 0; k < 100 && wr_cnt < 10; k++) tick();
    chk("rst10_reached", 64'(wr_cnt), 10);
    reset = 1'b1;
    tick();
    chk("rst10_outs", 64'({A, D, R, W, halt, busy, done}), 0);
    reset = 1'b0;
    sb.delete();
    for (int k = 0; k < 6; k++) tick();
    chk("rst10_nodone", 64'(done_cnt[0]), 0);
    chk("rst10_idle", 64'({halt, busy}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
